seq_divider: RTL and testbench

Sequential non-restoring divider for the CNN datapath. It is the inverse operation of the 12-bit-product Booth multiplier. It takes a 12-bit dividend (product-width) and an 8-bit divisor (operand-width) and produces one quotient bit per clock. It returns quotient and remainder with a single-cycle `ready` pulse. It is used for requantizing/normalizing multiplier products back to operand scale.

---
 rtl/seq_divider.sv | 159 +++++++++++++++
 tb/tb_seq_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider - sequential non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (unsigned otherwise). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int DIVIDEND_W = 12,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  // Two extra bits: one for |divisor| up to 2^DIVISOR_W, one for the shifted
  // partial remainder which spans [-2|d|, 2|d|) before the add/subtract.
  localparam int              PR_W  = DIVISOR_W + 2;
  localparam int              CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [DIVIDEND_W-1:0] dvd_q;  // dividend MSBs shift out, quotient bits shift in
  logic [DIVISOR_W:0]    dsr_q;
  logic [PR_W-1:0]       pr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  zero_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  dz_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
`ifdef DIV_SIGNED_EN
  logic                  neg_quot_q;
  logic                  neg_rem_q;
`endif

  logic [DIVIDEND_W-1:0] dvd_mag_d;
  logic [DIVISOR_W:0]    dsr_mag_d;
  logic [PR_W-1:0]       dsr_ext;
  logic [PR_W-1:0]       pr_shift;
  logic [PR_W-1:0]       pr_step;
  logic [DIVISOR_W-1:0]  rem_fix;
  logic [DIVIDEND_W-1:0] quot_fix_d;
  logic [DIVISOR_W-1:0]  rem_fix_d;

  always_comb begin
    dsr_ext  = {1'b0, dsr_q};
    pr_shift = {pr_q[PR_W-2:0], dvd_q[DIVIDEND_W-1]};
    pr_step  = pr_q[PR_W-1] ? (pr_shift + dsr_ext) : (pr_shift - dsr_ext);
    // Final remainder magnitude is below |divisor|, so the low bits suffice.
    rem_fix  = pr_q[PR_W-1] ? (pr_q[DIVISOR_W-1:0] + dsr_q[DIVISOR_W-1:0])
                            : pr_q[DIVISOR_W-1:0];
    quot_fix_d = dvd_q;
    rem_fix_d  = rem_fix;
`ifdef DIV_SIGNED_EN
    dvd_mag_d = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    dsr_mag_d = divisor[DIVISOR_W-1] ? -{divisor[DIVISOR_W-1], divisor}
                                     : {divisor[DIVISOR_W-1], divisor};
    if (neg_quot_q) quot_fix_d = -dvd_q;
    if (neg_rem_q)  rem_fix_d  = -rem_fix;
`else
    dvd_mag_d = dividend;
    dsr_mag_d = {1'b0, divisor};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            pr_q   <= '0;
            cnt_q  <= '0;
            dvd_q  <= dvd_mag_d;
            dsr_q  <= dsr_mag_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_rem_q  <= dividend[DIVIDEND_W-1];
`endif
            // A zero divisor skips the iterations; FIX loads the saturated result.
            if (divisor == '0) begin
              zero_q  <= 1'b1;
              state_q <= FIX;
            end else begin
              zero_q  <= 1'b0;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          pr_q  <= pr_step;
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], ~pr_step[PR_W-1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          if (zero_q) begin
            quot_q <= '1;
            rem_q  <= '0;
            dz_q   <= 1'b1;
          end else begin
            quot_q <= quot_fix_d;
            rem_q  <= rem_fix_d;
            dz_q   <= 1'b0;
          end
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign ready       = ready_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider - directed self-checking bench for seq_divider. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        ready;
  logic [11:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.DIVIDEND_W(12), .DIVISOR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .ready      (ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Waits for IDLE, issues one operation, returns the number of edges from
  // the accepting edge to the edge that raises ready (0 if it never came).
  task automatic run_op(input logic [11:0] a, input logic [7:0] b, output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (quotient !== 12'h000) begin n_fail++; $display("FAIL reset_quot: got %h expected 000", quotient); end
    n_checks++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL reset_rem: got %h expected 00", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int lat;
    run_op(12'd100, 8'd7, lat);
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL basic_latency: got %0d expected 13", lat); end
    n_checks++; if (quotient !== 12'd14) begin n_fail++; $display("FAIL basic_quot: got %0d expected 14", quotient); end
    n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL basic_rem: got %0d expected 2", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b expected 0", div_by_zero); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_ready: got %b expected 1", busy); end
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    n_checks++; if (quotient !== 12'd14) begin n_fail++; $display("FAIL basic_quot_hold: got %0d expected 14", quotient); end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    logic [11:0] av [6] = '{12'hF9C, 12'h064, 12'h800, 12'hFFF, 12'h064, 12'hF9C};
    logic [7:0]  bv [6] = '{8'h07,   8'h80,   8'hFF,   8'hFF,   8'hF9,   8'hF9};
    logic [11:0] qv [6] = '{12'hFF2, 12'h000, 12'h800, 12'h001, 12'hFF2, 12'h00E};
    logic [7:0]  rv [6] = '{8'hFE,   8'h64,   8'h00,   8'h00,   8'h02,   8'hFE};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], bv[i], lat);
      n_checks++; if (lat != 13) begin n_fail++; $display("FAIL signed_lat[%0d]: got %0d expected 13", i, lat); end
      n_checks++; if (quotient !== qv[i]) begin n_fail++; $display("FAIL signed_quot[%0d]: got %h expected %h", i, quotient, qv[i]); end
      n_checks++; if (remainder !== rv[i]) begin n_fail++; $display("FAIL signed_rem[%0d]: got %h expected %h", i, remainder, rv[i]); end
    end
  endtask
`else
  task automatic test_unsigned;
    // 0xF9C = 3996 = 7*570 + 6; 4095 = 255*16 + 15
    logic [11:0] av [4] = '{12'hF9C, 12'hFFF, 12'd5,   12'hFFF};
    logic [7:0]  bv [4] = '{8'd7,    8'hFF,   8'd200,  8'd1};
    logic [11:0] qv [4] = '{12'h23A, 12'd16,  12'd0,   12'hFFF};
    logic [7:0]  rv [4] = '{8'd6,    8'd15,   8'd5,    8'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], lat);
      n_checks++; if (lat != 13) begin n_fail++; $display("FAIL unsigned_lat[%0d]: got %0d expected 13", i, lat); end
      n_checks++; if (quotient !== qv[i]) begin n_fail++; $display("FAIL unsigned_quot[%0d]: got %h expected %h", i, quotient, qv[i]); end
      n_checks++; if (remainder !== rv[i]) begin n_fail++; $display("FAIL unsigned_rem[%0d]: got %h expected %h", i, remainder, rv[i]); end
    end
  endtask
`endif

  task automatic test_div_by_zero;
    int lat;
    run_op(12'd100, 8'd0, lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    n_checks++; if (quotient !== 12'hFFF) begin n_fail++; $display("FAIL dz_quot: got %h expected fff", quotient); end
    n_checks++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL dz_rem: got %h expected 00", remainder); end
    run_op(12'd9, 8'd3, lat);
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear: got %b expected 0", div_by_zero); end
    n_checks++; if (quotient !== 12'd3) begin n_fail++; $display("FAIL dz_next_quot: got %0d expected 3", quotient); end
    n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL dz_next_rem: got %0d expected 0", remainder); end
  endtask

  task automatic test_ignore_start;
    int lat;
    while (busy) begin @(posedge clk); #1; end
    dividend = 12'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 3 || k == 6) begin
        start    = 1'b1;
        dividend = 12'd9;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (ready) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 13", lat); end
    n_checks++; if (quotient !== 12'd14) begin n_fail++; $display("FAIL ignore_quot: got %0d expected 14", quotient); end
    n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL ignore_rem: got %0d expected 2", remainder); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int r1;
    int r2;
    while (busy) begin @(posedge clk); #1; end
    dividend = 12'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    r1 = 0;
    r2 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        if (r1 == 0) r1 = k;
        else begin
          r2 = k;
          break;
        end
      end
    end
    start = 1'b0;
    // Second acceptance lands on the edge after the single IDLE cycle: spacing N+3.
    n_checks++; if (r1 != 13) begin n_fail++; $display("FAIL b2b_first: got %0d expected 13", r1); end
    n_checks++; if (r2 - r1 != 15) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 15", r2 - r1); end
    n_checks++; if (quotient !== 12'd14) begin n_fail++; $display("FAIL b2b_quot: got %0d expected 14", quotient); end
  endtask

  task automatic test_reset_midop;
    int seen;
    int lat;
    while (busy) begin @(posedge clk); #1; end
    dividend = 12'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (quotient !== 12'h000) begin n_fail++; $display("FAIL midrst_quot: got %h expected 000", quotient); end
    n_checks++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL midrst_rem: got %h expected 00", remainder); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ready || busy) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_ready: got %0d active cycles expected 0", seen); end
    run_op(12'd50, 8'd5, lat);
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL midrst_next_lat: got %0d expected 13", lat); end
    n_checks++; if (quotient !== 12'd10) begin n_fail++; $display("FAIL midrst_next_quot: got %0d expected 10", quotient); end
    n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL midrst_next_rem: got %0d expected 0", remainder); end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_unsigned();
`endif
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
